rx_frm_acl_dispatch: RTL and testbench
======================================

Name: rx_frm_acl_dispatch

Overview:
Stage directly downstream of the RX ACL manager on one port's aggregated RX stream. It stores each frame and waits for its in-order ACL verdict (o_acl_vld/find_match/frmtype/fetch_info from the ACL manager). It then forwards the frame with frame-type and egress-port metadata, or drops it. Drop causes are: ACL miss, CRC error, or oversize.

Parameters:
PORT_NUM, 4, switch port count
PORT_MNG_DATA_WIDTH, 8, per-port MAC data width
CROSS_DATA_WIDTH, PORT_MNG_DATA_WIDTH*PORT_NUM, stream data width
FIFO_DEPTH, 512, data FIFO depth in beats (power of 2, >= MAX_FRM_BEATS)
MAX_FRM_BEATS, 400, maximum stored beats per frame
RSLT_DEPTH, 4, depth of the ACL-result FIFO and of the frame-status FIFO (power of 2)

Ports:
i_clk  in  1  single clock domain
i_rst  in  1  reset; asynchronous, active-low
i_mac_port_axi_data  in  CROSS_DATA_WIDTH+1  data beat; MSB = crcerr, valid on the last beat
i_mac_axi_data_keep  in  CROSS_DATA_WIDTH/8  byte enables
i_mac_axi_data_valid  in  1  beat valid
o_mac_axi_data_ready  out  1  beat accept
i_mac_axi_data_last  in  1  end of frame
i_acl_vld  in  1  ACL verdict strobe, one per frame, in frame order
i_acl_find_match  in  1  ACL hit
i_acl_frmtype  in  8  frame type
i_acl_fetch_info  in  16  [15:8] forward-port field
o_dsp_axi_data  out  CROSS_DATA_WIDTH  output beat (crcerr bit stripped)
o_dsp_axi_keep  out  CROSS_DATA_WIDTH/8  byte enables
o_dsp_axi_valid  out  1  output valid
i_dsp_axi_ready  in  1  downstream accept
o_dsp_axi_last  out  1  end of frame
o_dsp_frmtype  out  8  frame type; stable from first beat to last
o_dsp_fwd_port  out  PORT_NUM  i_acl_fetch_info[8 +: PORT_NUM]; stable for the frame
o_pass_cnt  out  16  frames forwarded, saturating
o_drop_cnt  out  16  frames dropped, saturating
o_rslt_ovf  out  1  sticky: verdict arrived while the result FIFO was full

Behaviour:
- Reset (i_rst low, asynchronous): all FIFOs emptied, FSM to IDLE. Every output is 0, including o_mac_axi_data_ready, the counters and o_rslt_ovf.
- Write side:
  - o_mac_axi_data_ready = data FIFO not full AND frame-status FIFO not full, or writer in DISCARD state.
  - An accepted beat stores {last, keep, data}. On the last beat, push a status entry {crcerr, oversize=0}.
  - A per-frame beat counter runs. If MAX_FRM_BEATS beats are stored without last, the final stored beat gets last=1 and status {crcerr=0, oversize=1} is pushed.
  - DISCARD state: ready=1, input beats are accepted and ignored through the input last, then writing resumes.
- Result FIFO: every i_acl_vld pushes {find_match, frmtype, fetch_info}. If the FIFO is full, the verdict is lost and o_rslt_ovf is set; it clears only on reset.
- Read FSM:
  - IDLE: when the status FIFO and result FIFO are both non-empty, pop one entry from each and go to DECIDE.
  - DECIDE (1 cycle): PASS if find_match & !crcerr & !oversize, otherwise DROP. Metadata registers load here.
  - PASS: beats are presented with AXI semantics. Data, keep and last hold while valid & !ready. A beat pops on valid & ready. After last pops: o_pass_cnt++ and go to IDLE.
  - DROP: pop one beat per cycle, o_dsp_axi_valid stays 0. After the last pops: o_drop_cnt++ and go to IDLE.
- Latency: the first o_dsp_axi_valid occurs 3 cycles after the later of (last beat accepted, i_acl_vld). There is one idle cycle between frames.
- Data FIFO simultaneous read and write at full or empty: full blocks the write; the read is only initiated while the status FIFO is non-empty, so an empty read cannot occur.
- Pointers wrap modulo depth, with an extra MSB for full/empty detection.
- Counters saturate at 16'hFFFF.

Test Plan:
- 16-beat frame, crcerr=0; verdict match=1, frmtype=8'h05, fetch_info=16'h0300 -> 16 output beats, frmtype=5, fwd_port=4'b0011, pass_cnt=1.
- Same frame with match=0 -> no o_dsp_axi_valid, FIFO drained, drop_cnt=1.
- Match=1 but last beat MSB crcerr=1 -> dropped, drop_cnt=1.
- 500-beat frame, MAX_FRM_BEATS=400 -> 400 stored, 100 discarded with ready=1; frame dropped; next frame passes intact.
- Three verdicts issued before any frame completes, then three frames; random i_dsp_axi_ready -> correct in-order metadata, data stable under stall; a 5th verdict while 4 are queued sets o_rslt_ovf.
- Assert i_rst low mid-PASS -> all outputs 0 immediately; after release a new frame passes correctly.

Source files
------------

// File: rtl/rx_frm_acl_dispatch.sv
// rx_frm_acl_dispatch: buffers RX frames, pairs each one with its in-order
// ACL verdict, then forwards it with frame metadata or drops it.
module rx_frm_acl_dispatch #(
  parameter int PORT_NUM            = 4,
  parameter int PORT_MNG_DATA_WIDTH = 8,
  parameter int CROSS_DATA_WIDTH    = PORT_MNG_DATA_WIDTH*PORT_NUM,
  parameter int FIFO_DEPTH          = 512,
  parameter int MAX_FRM_BEATS       = 400,
  parameter int RSLT_DEPTH          = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [CROSS_DATA_WIDTH:0]     i_mac_port_axi_data,
  input  logic [CROSS_DATA_WIDTH/8-1:0] i_mac_axi_data_keep,
  input  logic                          i_mac_axi_data_valid,
  output logic                          o_mac_axi_data_ready,
  input  logic                          i_mac_axi_data_last,
  input  logic                          i_acl_vld,
  input  logic                          i_acl_find_match,
  input  logic [7:0]                    i_acl_frmtype,
  input  logic [15:0]                   i_acl_fetch_info,
  output logic [CROSS_DATA_WIDTH-1:0]   o_dsp_axi_data,
  output logic [CROSS_DATA_WIDTH/8-1:0] o_dsp_axi_keep,
  output logic                          o_dsp_axi_valid,
  input  logic                          i_dsp_axi_ready,
  output logic                          o_dsp_axi_last,
  output logic [7:0]                    o_dsp_frmtype,
  output logic [PORT_NUM-1:0]           o_dsp_fwd_port,
  output logic [15:0]                   o_pass_cnt,
  output logic [15:0]                   o_drop_cnt,
  output logic                          o_rslt_ovf
);

  localparam int CW = CROSS_DATA_WIDTH;
  localparam int KW = CROSS_DATA_WIDTH/8;
  localparam int DW = CW + KW + 1;
  localparam int DA = $clog2(FIFO_DEPTH);
  localparam int SA = $clog2(RSLT_DEPTH);
  localparam int BW = $clog2(MAX_FRM_BEATS+1);
  localparam int VW = 1 + 8 + PORT_NUM;

  typedef enum logic {
    W_STORE,
    W_DISC
  } wst_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_DECIDE,
    RD_PASS,
    RD_DROP
  } rst_t;

  wst_t w_st, w_nxt;
  rst_t rd_st, rd_nxt;

  logic run;

  logic [DW-1:0] dmem [FIFO_DEPTH];
  logic [DA:0]   dwp, drp;
  logic          d_full, d_empty;
  logic          d_wr, d_rd;
  logic [DW-1:0] d_din, d_head;

  logic [1:0]    smem [RSLT_DEPTH];
  logic [SA:0]   swp, srp;
  logic          s_full, s_empty;
  logic          s_wr, s_rd;
  logic          s_crc, s_ovs;

  logic [VW-1:0] vmem [RSLT_DEPTH];
  logic [SA:0]   vwp, vrp;
  logic          v_full, v_empty;
  logic          v_wr, v_rd;
  logic [VW-1:0] v_din;

  logic [BW-1:0] bcnt;
  logic          bcnt_clr, bcnt_inc;
  logic          w_last;
  logic          in_ready;

  logic          cur_crc, cur_ovs, cur_match;
  logic [7:0]    cur_ftype;
  logic [PORT_NUM-1:0] cur_fwd;

  logic          out_valid;
  logic          meta_ld;
  logic          pass_inc, drop_inc;

  logic          unused_info;
  assign unused_info = ^i_acl_fetch_info;

  assign d_full  = (dwp[DA] != drp[DA]) &&
                   (dwp[DA-1:0] == drp[DA-1:0]);
  assign d_empty = (dwp == drp);
  assign s_full  = (swp[SA] != srp[SA]) &&
                   (swp[SA-1:0] == srp[SA-1:0]);
  assign s_empty = (swp == srp);
  assign v_full  = (vwp[SA] != vrp[SA]) &&
                   (vwp[SA-1:0] == vrp[SA-1:0]);
  assign v_empty = (vwp == vrp);

  assign d_head = dmem[drp[DA-1:0]];
  assign d_din  = {w_last, i_mac_axi_data_keep,
                   i_mac_port_axi_data[CW-1:0]};
  assign v_din  = {i_acl_find_match, i_acl_frmtype,
                   i_acl_fetch_info[8 +: PORT_NUM]};
  assign v_wr   = i_acl_vld && !v_full;

  assign o_mac_axi_data_ready = in_ready;
  assign o_dsp_axi_valid = out_valid;
  assign o_dsp_axi_data  = out_valid ? d_head[CW-1:0] : '0;
  assign o_dsp_axi_keep  = out_valid ? d_head[CW +: KW] : '0;
  assign o_dsp_axi_last  = out_valid && d_head[DW-1];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      w_st  <= W_STORE;
      rd_st <= RD_IDLE;
    end else begin
      w_st  <= w_nxt;
      rd_st <= rd_nxt;
    end
  end

  // A frame hitting MAX_FRM_BEATS is closed early; its tail is swallowed.
  always_comb begin
    w_nxt    = w_st;
    in_ready = 1'b0;
    d_wr     = 1'b0;
    s_wr     = 1'b0;
    s_crc    = 1'b0;
    s_ovs    = 1'b0;
    w_last   = 1'b0;
    bcnt_clr = 1'b0;
    bcnt_inc = 1'b0;
    unique case (w_st)
      W_STORE: begin
        in_ready = run && !d_full && !s_full;
        if (i_mac_axi_data_valid && in_ready) begin
          d_wr = 1'b1;
          if (i_mac_axi_data_last) begin
            w_last   = 1'b1;
            s_wr     = 1'b1;
            s_crc    = i_mac_port_axi_data[CW];
            bcnt_clr = 1'b1;
          end else if (bcnt == BW'(MAX_FRM_BEATS-1)) begin
            w_last   = 1'b1;
            s_wr     = 1'b1;
            s_ovs    = 1'b1;
            bcnt_clr = 1'b1;
            w_nxt    = W_DISC;
          end else begin
            bcnt_inc = 1'b1;
          end
        end
      end
      W_DISC: begin
        in_ready = 1'b1;
        if (i_mac_axi_data_valid && i_mac_axi_data_last)
          w_nxt = W_STORE;
      end
      default: w_nxt = W_STORE;
    endcase
  end

  always_comb begin
    rd_nxt    = rd_st;
    s_rd      = 1'b0;
    v_rd      = 1'b0;
    d_rd      = 1'b0;
    out_valid = 1'b0;
    meta_ld   = 1'b0;
    pass_inc  = 1'b0;
    drop_inc  = 1'b0;
    unique case (rd_st)
      RD_IDLE: begin
        if (!s_empty && !v_empty) begin
          s_rd   = 1'b1;
          v_rd   = 1'b1;
          rd_nxt = RD_DECIDE;
        end
      end
      RD_DECIDE: begin
        meta_ld = 1'b1;
        if (cur_match && !cur_crc && !cur_ovs)
          rd_nxt = RD_PASS;
        else
          rd_nxt = RD_DROP;
      end
      RD_PASS: begin
        out_valid = !d_empty;
        if (out_valid && i_dsp_axi_ready) begin
          d_rd = 1'b1;
          if (d_head[DW-1]) begin
            pass_inc = 1'b1;
            rd_nxt   = RD_IDLE;
          end
        end
      end
      RD_DROP: begin
        if (!d_empty) begin
          d_rd = 1'b1;
          if (d_head[DW-1]) begin
            drop_inc = 1'b1;
            rd_nxt   = RD_IDLE;
          end
        end
      end
      default: rd_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (d_wr)
      dmem[dwp[DA-1:0]] <= d_din;
    if (s_wr)
      smem[swp[SA-1:0]] <= {s_crc, s_ovs};
    if (v_wr)
      vmem[vwp[SA-1:0]] <= v_din;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      run  <= 1'b0;
      dwp  <= '0;
      drp  <= '0;
      swp  <= '0;
      srp  <= '0;
      vwp  <= '0;
      vrp  <= '0;
      bcnt <= '0;
    end else begin
      run <= 1'b1;
      if (d_wr)
        dwp <= dwp + (DA+1)'(1);
      if (d_rd)
        drp <= drp + (DA+1)'(1);
      if (s_wr)
        swp <= swp + (SA+1)'(1);
      if (s_rd)
        srp <= srp + (SA+1)'(1);
      if (v_wr)
        vwp <= vwp + (SA+1)'(1);
      if (v_rd)
        vrp <= vrp + (SA+1)'(1);
      if (bcnt_clr)
        bcnt <= '0;
      else if (bcnt_inc)
        bcnt <= bcnt + BW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cur_crc        <= 1'b0;
      cur_ovs        <= 1'b0;
      cur_match      <= 1'b0;
      cur_ftype      <= '0;
      cur_fwd        <= '0;
      o_dsp_frmtype  <= '0;
      o_dsp_fwd_port <= '0;
      o_pass_cnt     <= '0;
      o_drop_cnt     <= '0;
      o_rslt_ovf     <= 1'b0;
    end else begin
      if (s_rd)
        {cur_crc, cur_ovs} <= smem[srp[SA-1:0]];
      if (v_rd)
        {cur_match, cur_ftype, cur_fwd} <= vmem[vrp[SA-1:0]];
      if (meta_ld) begin
        o_dsp_frmtype  <= cur_ftype;
        o_dsp_fwd_port <= cur_fwd;
      end
      if (pass_inc && o_pass_cnt != 16'hFFFF)
        o_pass_cnt <= o_pass_cnt + 16'd1;
      if (drop_inc && o_drop_cnt != 16'hFFFF)
        o_drop_cnt <= o_drop_cnt + 16'd1;
      if (i_acl_vld && v_full)
        o_rslt_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_frm_acl_dispatch.sv
// tb_rx_frm_acl_dispatch: directed + randomized frames and verdicts,
// checked beat by beat against a frame/verdict pairing model.
module tb_rx_frm_acl_dispatch;

  localparam int PN   = 4;
  localparam int CW   = 32;
  localparam int KW   = 4;
  localparam int MAXB = 400;

  logic          clk;
  logic          i_rst;
  logic [CW:0]   i_mac_port_axi_data;
  logic [KW-1:0] i_mac_axi_data_keep;
  logic          i_mac_axi_data_valid;
  logic          o_mac_axi_data_ready;
  logic          i_mac_axi_data_last;
  logic          i_acl_vld;
  logic          i_acl_find_match;
  logic [7:0]    i_acl_frmtype;
  logic [15:0]   i_acl_fetch_info;
  logic [CW-1:0] o_dsp_axi_data;
  logic [KW-1:0] o_dsp_axi_keep;
  logic          o_dsp_axi_valid;
  logic          i_dsp_axi_ready;
  logic          o_dsp_axi_last;
  logic [7:0]    o_dsp_frmtype;
  logic [PN-1:0] o_dsp_fwd_port;
  logic [15:0]   o_pass_cnt;
  logic [15:0]   o_drop_cnt;
  logic          o_rslt_ovf;

  rx_frm_acl_dispatch dut (
    .i_clk                (clk),
    .i_rst                (i_rst),
    .i_mac_port_axi_data  (i_mac_port_axi_data),
    .i_mac_axi_data_keep  (i_mac_axi_data_keep),
    .i_mac_axi_data_valid (i_mac_axi_data_valid),
    .o_mac_axi_data_ready (o_mac_axi_data_ready),
    .i_mac_axi_data_last  (i_mac_axi_data_last),
    .i_acl_vld            (i_acl_vld),
    .i_acl_find_match     (i_acl_find_match),
    .i_acl_frmtype        (i_acl_frmtype),
    .i_acl_fetch_info     (i_acl_fetch_info),
    .o_dsp_axi_data       (o_dsp_axi_data),
    .o_dsp_axi_keep       (o_dsp_axi_keep),
    .o_dsp_axi_valid      (o_dsp_axi_valid),
    .i_dsp_axi_ready      (i_dsp_axi_ready),
    .o_dsp_axi_last       (o_dsp_axi_last),
    .o_dsp_frmtype        (o_dsp_frmtype),
    .o_dsp_fwd_port       (o_dsp_fwd_port),
    .o_pass_cnt           (o_pass_cnt),
    .o_drop_cnt           (o_drop_cnt),
    .o_rslt_ovf           (o_rslt_ovf)
  );

  typedef struct packed {
    logic          last;
    logic [KW-1:0] keep;
    logic [CW-1:0] data;
  } sbeat_t;

  typedef struct packed {
    logic [7:0]    ft;
    logic [PN-1:0] fwd;
    sbeat_t        b;
  } obeat_t;

  typedef struct packed {
    logic crc;
    logic ovs;
  } fst_t;

  typedef struct packed {
    logic        m;
    logic [7:0]  ft;
    logic [15:0] info;
  } vd_t;

  sbeat_t bq[$];
  fst_t   fq[$];
  vd_t    vq[$];
  obeat_t expq[$];

  int nvec = 0;
  int nerr = 0;
  int exp_pass = 0;
  int exp_drop = 0;
  int mon_beats = 0;
  bit rand_rdy = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Pair stored frames with verdicts in arrival order.
  function automatic void reconcile();
    fst_t   f;
    vd_t    v;
    sbeat_t b;
    bit     pass;
    while (fq.size() > 0 && vq.size() > 0) begin
      f = fq.pop_front();
      v = vq.pop_front();
      pass = v.m && !f.crc && !f.ovs;
      if (pass) exp_pass++;
      else exp_drop++;
      do begin
        b = bq.pop_front();
        if (pass) expq.push_back({v.ft, v.info[8 +: PN], b});
      end while (!b.last);
    end
  endfunction

  task automatic send_verdict(input logic m, input logic [7:0] ft,
                              input logic [15:0] info, input bit lost);
    i_acl_vld        = 1'b1;
    i_acl_find_match = m;
    i_acl_frmtype    = ft;
    i_acl_fetch_info = info;
    @(posedge clk); #1;
    i_acl_vld = 1'b0;
    if (!lost) begin
      vq.push_back({m, ft, info});
      reconcile();
    end
  endtask

  task automatic send_frame(input int len, input bit crc, input bit gaps,
                            output int dstall);
    dstall = 0;
    for (int i = 0; i < len; i++) begin
      logic [CW:0]   d;
      logic [KW-1:0] k;
      logic          l, fl;
      bit            acc;
      int            w;
      d  = {1'($urandom), $urandom};
      k  = KW'($urandom);
      l  = (i == len - 1);
      fl = l || (i == MAXB - 1);
      if (l) d[CW] = crc;
      if (i < MAXB) begin
        bq.push_back({fl, k, d[CW-1:0]});
        if (l) fq.push_back({crc, 1'b0});
        else if (i == MAXB - 1) fq.push_back(2'b01);
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        i_mac_axi_data_valid = 1'b0;
        @(posedge clk); #1;
      end
      i_mac_port_axi_data  = d;
      i_mac_axi_data_keep  = k;
      i_mac_axi_data_last  = l;
      i_mac_axi_data_valid = 1'b1;
      acc = 0;
      w = 0;
      while (!acc && w < 3000) begin
        @(negedge clk);
        acc = o_mac_axi_data_ready;
        @(posedge clk); #1;
        if (!acc && i >= MAXB) dstall++;
        w++;
      end
      chk("wr_accept", acc, 1);
      i_mac_axi_data_valid = 1'b0;
      i_mac_axi_data_last  = 1'b0;
    end
    reconcile();
  endtask

  task automatic wait_done(input string tag);
    int w = 0;
    while ((expq.size() != 0 || o_pass_cnt != 16'(exp_pass) ||
            o_drop_cnt != 16'(exp_drop)) && w < 5000) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (3) begin @(posedge clk); #1; end
    chk({tag, "_pass"}, o_pass_cnt, exp_pass);
    chk({tag, "_drop"}, o_drop_cnt, exp_drop);
    chk({tag, "_drained"}, expq.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, o_mac_axi_data_ready, 0);
    chk({tag, "_valid"}, o_dsp_axi_valid, 0);
    chk({tag, "_beat"},
        {o_dsp_axi_last, o_dsp_axi_keep, o_dsp_axi_data}, 0);
    chk({tag, "_meta"}, {o_dsp_frmtype, o_dsp_fwd_port}, 0);
    chk({tag, "_cnt"}, {o_pass_cnt, o_drop_cnt, o_rslt_ovf}, 0);
  endtask

  initial forever begin
    @(posedge clk); #1;
    i_dsp_axi_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic               pstall;
  logic [CW+KW:0]     pbeat;

  initial forever begin
    obeat_t e;
    @(negedge clk);
    if (!i_rst) begin
      pstall = 1'b0;
    end else begin
      if (o_dsp_axi_valid) begin
        if (pstall)
          chk("stall_hold",
              {o_dsp_axi_last, o_dsp_axi_keep, o_dsp_axi_data}, pbeat);
        if (i_dsp_axi_ready) begin
          chk("unexp_valid", expq.size() != 0, 1);
          if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("beat", {o_dsp_frmtype, o_dsp_fwd_port, o_dsp_axi_last,
                         o_dsp_axi_keep, o_dsp_axi_data}, e);
            mon_beats++;
          end
        end
      end
      pstall = o_dsp_axi_valid && !i_dsp_axi_ready;
      pbeat  = {o_dsp_axi_last, o_dsp_axi_keep, o_dsp_axi_data};
    end
  end

  initial begin
    int st, lat, base, w, len;
    logic m, crc;
    i_rst                = 1'b0;
    i_mac_port_axi_data  = '0;
    i_mac_axi_data_keep  = '0;
    i_mac_axi_data_valid = 1'b0;
    i_mac_axi_data_last  = 1'b0;
    i_acl_vld            = 1'b0;
    i_acl_find_match     = 1'b0;
    i_acl_frmtype        = '0;
    i_acl_fetch_info     = '0;
    i_dsp_axi_ready      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("rst");
    i_rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", o_mac_axi_data_ready, 1);

    send_verdict(1'b1, 8'h05, 16'h0300, 0);
    send_frame(16, 1'b0, 1'b0, st);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!o_dsp_axi_valid && lat < 20);
    chk("latency", lat, 3);
    @(posedge clk); #1;
    wait_done("t1");
    chk("t1_ftype", o_dsp_frmtype, 8'h05);
    chk("t1_fwd", o_dsp_fwd_port, 4'b0011);

    send_verdict(1'b0, 8'h11, 16'h0100, 0);
    send_frame(16, 1'b0, 1'b0, st);
    wait_done("t2_miss");

    send_verdict(1'b1, 8'h22, 16'h0f00, 0);
    send_frame(16, 1'b1, 1'b0, st);
    wait_done("t3_crc");

    send_verdict(1'b1, 8'h33, 16'h0500, 0);
    send_frame(500, 1'b0, 1'b0, st);
    chk("disc_stall", st, 0);
    send_verdict(1'b1, 8'h44, 16'h0a00, 0);
    send_frame(20, 1'b0, 1'b1, st);
    wait_done("t4_over");

    rand_rdy = 1;
    for (int i = 0; i < 3; i++)
      send_verdict(1'b1, 8'($urandom), 16'($urandom), 0);
    send_frame(1, 1'b0, 1'b1, st);
    send_frame($urandom_range(2, 40), 1'b0, 1'b1, st);
    send_frame($urandom_range(2, 40), 1'b0, 1'b1, st);
    wait_done("t5_order");

    chk("ovf_clear", o_rslt_ovf, 0);
    for (int i = 0; i < 4; i++)
      send_verdict(1'($urandom_range(0, 3) != 0), 8'($urandom),
                   16'($urandom), 0);
    send_verdict(1'b1, 8'hee, 16'hffff, 1);
    chk("ovf_set", o_rslt_ovf, 1);
    for (int i = 0; i < 4; i++)
      send_frame($urandom_range(1, 40), 1'($urandom_range(0, 3) == 0),
                 1'b1, st);
    wait_done("t6_ovf");
    chk("ovf_sticky", o_rslt_ovf, 1);

    rand_rdy = 0;
    for (int i = 0; i < 10; i++) begin
      m   = 1'($urandom_range(0, 3) != 0);
      crc = 1'($urandom_range(0, 4) == 0);
      len = $urandom_range(1, 64);
      if ($urandom_range(0, 1) == 1) begin
        send_verdict(m, 8'($urandom), 16'($urandom), 0);
        send_frame(len, crc, 1'b1, st);
      end else begin
        send_frame(len, crc, 1'b1, st);
        send_verdict(m, 8'($urandom), 16'($urandom), 0);
      end
    end
    wait_done("t7_rand");

    send_verdict(1'b1, 8'h5a, 16'h0c00, 0);
    send_frame(64, 1'b0, 1'b0, st);
    base = mon_beats;
    w = 0;
    while (mon_beats < base + 8 && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    chk("t8_midpass", o_dsp_axi_valid, 1);
    #2 i_rst = 1'b0;
    #1;
    chk_zero("t8_rst");
    bq.delete();
    fq.delete();
    vq.delete();
    expq.delete();
    exp_pass = 0;
    exp_drop = 0;
    @(posedge clk);
    @(negedge clk);
    i_rst = 1'b1;
    @(posedge clk); #1;
    send_verdict(1'b1, 8'h77, 16'h0900, 0);
    send_frame(16, 1'b0, 1'b1, st);
    wait_done("t8_after");
    chk("t8_ftype", o_dsp_frmtype, 8'h77);
    chk("t8_fwd", o_dsp_fwd_port, 4'b1001);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
